// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM-subset multicycle controller.
// Contents:
//   state_e          - main sequencer states (numeric values are the State debug codes)
//   OP_*             - instruction class codes (Instr Op field)
//   CMD_*            - data-processing command codes (Funct[4:1])
//   COND_*           - condition field codes
//   ALU_*/RES_*/SRCB_* - datapath mux / ALU operation encodings
//   alu_decode()     - data-processing command -> ALUControl
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // MOV passes the operand through the adder (Rn reads as zero), and any
  // unrecognised command also falls back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: alu_decode = ALU_SUB;
      CMD_AND:          alu_decode = ALU_AND;
      CMD_ORR:          alu_decode = ALU_ORR;
      default:          alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Combinational ARM condition evaluation.
// Ports:
//   cond    in  4  condition field of the instruction
//   flags   in  4  NZCV flag register contents
//   cond_ex out 1  instruction should execute
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    // NOTE: a default assigned before the case keeps this block purely
    // combinational; any path that skipped the assignment would infer a latch.
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;   // 1111: never
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the ARM-subset datapath (shared ALU and memory).
// Holds the main FSM, the NZCV flag register and the condition-pass bit
// registered in DECODE, and drives every datapath enable and mux select.
// Ports:
//   CLK        in   1  clock, rising edge
//   reset      in   1  synchronous, active-high
//   Instr      in  20  Instr[31:12]: Cond[19:16] Op[15:14] Funct[13:8] Rd[3:0]
//   ALUFlags   in   4  NZCV from the ALU this cycle
//   MemReady   in   1  memory completes its access this cycle
//   PCWrite    out  1  PC enable
//   AdrSrc     out  1  memory address: 0=PC 1=ALUOut
//   MemWrite   out  1  data memory write strobe
//   IRWrite    out  1  instruction register enable
//   RegWrite   out  1  register file write enable
//   ResultSrc  out  2  00=ALUOut 01=ReadData 10=ALUResult
//   ALUSrcA    out  1  0=RD1 1=PC
//   ALUSrcB    out  2  00=RD2 01=ExtImm 10=4
//   ALUControl out  2  00=ADD 01=SUB 10=AND 11=ORR
//   ImmSrc     out  2  immediate format (= Op)
//   RegSrc     out  2  [0]: Op is branch, [1]: Op is memory
//   MOVInstr   out  1  MOV in EXECR/EXECI/ALUWB
//   State      out STATE_W current state (debug)
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic               MOVInstr,
  output logic [STATE_W-1:0] State
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign cmd       = funct[4:1];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_e     state_q, state_d, cur_state;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex_now;
  logic [1:0] alu_ctl;

  // Raw per-state strobes, gated by the registered condition below.
  logic ir_w, pc_fetch, reg_w, mem_w, branch, no_write;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex_now)
  );

  // While reset is high the muxes present their FETCH values.
  assign cur_state = reset ? S_FETCH : state_q;
  assign alu_ctl   = alu_decode(cmd);

  always_comb begin
    state_d    = S_FETCH;
    flags_d    = flags_q;
    cond_ex_d  = cond_ex_q;
    ir_w       = 1'b0;
    pc_fetch   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    no_write   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    MOVInstr   = 1'b0;

    case (cur_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_w      = MemReady;
        pc_fetch  = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;        // PC+8 for operands that read R15
        ALUSrcB   = SRCB_FOUR;
        cond_ex_d = cond_ex_now;
        case (op)
          OP_DP:  state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM: state_d = S_MEMADR;
          OP_BR:  state_d = S_BRANCH;
          OP_NOP: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;   // U bit: add/subtract offset
        state_d    = funct[0] ? S_MEMRD : S_MEMWR;   // L bit
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;          // strobe stays up for the whole wait
        state_d = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (cur_state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
        ALUControl = alu_ctl;
        MOVInstr   = (cmd == CMD_MOV);
        state_d    = S_ALUWB;
        // S bit: logical ops leave C and V untouched.
        if (cond_ex_q && funct[0]) begin
          flags_d[3:2] = ALUFlags[3:2];
          if ((alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB)) begin
            flags_d[1:0] = ALUFlags[1:0];
          end
        end
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_w     = 1'b1;
        no_write  = (cmd == CMD_CMP);
        MOVInstr  = (cmd == CMD_MOV);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: ;                 // undefined encodings: all quiet, back to FETCH
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: reset here is sampled on the clock edge, not in the sensitivity
    // list; every flop is cleared so an aborted instruction leaves no trace.
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign IRWrite  = ~reset & ir_w;
  assign RegWrite = ~reset & reg_w & cond_ex_q & ~no_write;
  assign MemWrite = ~reset & mem_w & cond_ex_q;
  assign PCWrite  = ~reset & (pc_fetch
                             | (branch & cond_ex_q)
                             | (reg_w & (rd == 4'hF) & cond_ex_q));

  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign State  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        CLK = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, MOVInstr;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;

  always #5 CLK = ~CLK;

  multicycle_controller #(.STATE_W(4)) dut (
    .CLK(CLK), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .MOVInstr(MOVInstr),
    .State(State)
  );

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic       mov;
    logic [3:0] state;
  } outs_t;

  outs_t got, exp_o;
  logic  exp_valid = 1'b0;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc, MOVInstr, State};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, g, e);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_valid) check("cycle outputs", 32'(got), 32'(exp_o));
  end

  // ---------------- behavioural model ----------------
  // Each instruction is a list of state numbers it visits; FETCH (0),
  // MEMRD (3) and MEMWR (5) repeat while MemReady is low.
  int          path[$];
  int          idx;
  logic [19:0] cur_instr;
  logic [19:0] pending[$];
  logic [3:0]  m_flags;
  logic        m_condex;
  logic        p_rst, p_mr;
  logic [3:0]  p_af;
  bit          started = 0;

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0000:          return 2'd2;
      4'b1100:          return 2'd3;
      4'b0010, 4'b1010: return 2'd1;
      default:          return 2'd0;
    endcase
  endfunction

  // Condition = base test on cond[3:1], inverted by cond[0] (AL^1 = never).
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic outs_t expect_outs(input int st, input logic [19:0] ins,
                                        input logic cex, input logic mr, input logic rst);
    outs_t o;
    logic [3:0] cmd;
    logic rd15;
    o = '0;
    cmd = ins[12:9];
    rd15 = (ins[3:0] == 4'hF);
    case (rst ? 0 : st)
      0: begin o.srca = 1; o.srcb = 2; o.res = 2; o.irw = mr; o.pcw = mr; end
      1: begin o.srca = 1; o.srcb = 2; end
      2: begin o.srcb = 1; o.aluc = ins[11] ? 2'd0 : 2'd1; end
      3: o.adr = 1;
      4: begin o.res = 1; o.regw = cex; o.pcw = cex & rd15; end
      5: begin o.adr = 1; o.memw = cex; end
      6, 7: begin
        o.srcb = (st == 7) ? 2'd1 : 2'd0;
        o.aluc = alu_of(cmd);
        o.mov  = (cmd == 4'b1101);
      end
      8: begin o.regw = cex & (cmd != 4'b1010); o.pcw = cex & rd15; o.mov = (cmd == 4'b1101); end
      9: begin o.srcb = 1; o.res = 2; o.pcw = cex; end
      default: ;
    endcase
    if (rst) begin o.pcw = 0; o.irw = 0; end
    o.imm    = ins[15:14];
    o.regsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
    o.state  = st[3:0];
    return o;
  endfunction

  task automatic start_instr();
    logic [31:0] r;
    if (pending.size() > 0) cur_instr = pending.pop_front();
    else begin
      r = $urandom;
      cur_instr = r[19:0];
      if (r[20]) cur_instr[19:16] = 4'hE;
      if (r[23:21] == 3'd0) cur_instr[3:0] = 4'hF;
    end
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (cur_instr[15:14])
      2'b00: begin path.push_back(cur_instr[13] ? 7 : 6); path.push_back(8); end
      2'b01: begin
        path.push_back(2);
        if (cur_instr[8]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'b10: path.push_back(9);
      default: ;
    endcase
    idx = 0;
  endtask

  task automatic advance();
    int cur;
    logic [1:0] a;
    if (p_rst) begin
      m_flags = 4'h0;
      m_condex = 1'b0;
      start_instr();
      return;
    end
    cur = path[idx];
    a = alu_of(cur_instr[12:9]);
    if (cur == 1) m_condex = cond_holds(cur_instr[19:16], m_flags);
    if ((cur == 6 || cur == 7) && m_condex && cur_instr[8]) begin
      m_flags[3:2] = p_af[3:2];
      if (a[1] == 1'b0) m_flags[1:0] = p_af[1:0];
    end
    if (!((cur == 0 || cur == 3 || cur == 5) && !p_mr)) idx++;
    if (idx >= path.size()) start_instr();
  endtask

  // One clock: retire the previous cycle in the model, drive new inputs,
  // return just after the falling edge so callers can sample outputs.
  task automatic cyc(input logic rst, input logic mr, input logic [3:0] af);
    if (started) begin
      @(posedge CLK);
      #1;
      advance();
      exp_valid = 1'b1;
    end
    started = 1;
    reset = rst;
    MemReady = mr;
    ALUFlags = af;
    Instr = cur_instr;
    p_rst = rst;
    p_mr = mr;
    p_af = af;
    exp_o = expect_outs(path[idx], cur_instr, m_condex, mr, rst);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    m_flags = 4'h0;
    m_condex = 1'b0;
    cur_instr = 20'h0;
    path.push_back(0);
    idx = 0;
    pending.push_back(20'hE0921);   // ADDS R1,R2,R3
    pending.push_back(20'h0A000);   // BEQ
    pending.push_back(20'hE5921);   // LDR R1,[R2,#4]
    pending.push_back(20'hE3510);   // CMP R1,#5
    pending.push_back(20'h0A000);   // BEQ
    pending.push_back(20'hE5821);   // STR R1,[R2]

    cyc(1, 1, 4'h0);
    check("reset PCWrite", PCWrite, 0);
    check("reset IRWrite", IRWrite, 0);
    // ADDS
    cyc(0, 1, 4'h0);
    check("fetch State", State, 0);
    check("fetch PCWrite", PCWrite, 1);
    check("fetch IRWrite", IRWrite, 1);
    cyc(0, 1, 4'h0);
    check("adds decode", State, 1);
    cyc(0, 1, 4'b0100);
    check("adds execr", State, 6);
    check("adds execr RegWrite", RegWrite, 0);
    cyc(0, 1, 4'h0);
    check("adds aluwb", State, 8);
    check("adds aluwb RegWrite", RegWrite, 1);
    // BEQ with Z=1
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    check("beq taken State", State, 9);
    check("beq taken PCWrite", PCWrite, 1);
    // LDR with a 3-cycle memory stall
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    check("ldr memadr", State, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'h0);
      check("ldr memrd stall", State, 3);
    end
    cyc(0, 1, 4'h0);
    check("ldr memrd ready", State, 3);
    cyc(0, 1, 4'h0);
    check("ldr memwb", State, 4);
    check("ldr memwb ResultSrc", ResultSrc, 1);
    // CMP R1,#5 with result flags 0000
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    check("cmp execi", State, 7);
    check("cmp ALUControl", ALUControl, 1);
    cyc(0, 1, 4'h0);
    check("cmp aluwb", State, 8);
    check("cmp RegWrite", RegWrite, 0);
    // BEQ with Z=0
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    check("beq not taken State", State, 9);
    check("beq not taken PCWrite", PCWrite, 0);
    // STR aborted by reset in MEMADR
    cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    cyc(1, 1, 4'h0);
    check("str reset memadr", State, 2);
    check("str reset MemWrite", MemWrite, 0);
    cyc(0, 1, 4'h0);
    check("str after reset", State, 0);
    check("str after reset MemWrite", MemWrite, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
